// File: rtl/register_bank_arbiter_pkg.sv
// Shared types and helpers for register_bank_arbiter: FSM state encoding and
// a constant clog2 used to size the round-robin pointer and winner index.
package register_bank_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/register_bank_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester
// at or after rr_ptr_i (cyclically) with its request bit high.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [PTR_W-1:0]   winner_o,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic               any_req_o
);

  logic [NUM_REQ-1:0] masked;

  // Lowest request at/above the pointer wins; if none, wrap to lowest overall.
  always_comb begin
    masked      = '0;
    winner_o    = '0;
    winner_oh_o = '0;
    any_req_o   = |req_i;
    for (int i = 0; i < NUM_REQ; i++)
      masked[i] = req_i[i] && (PTR_W'(i) >= rr_ptr_i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[i]) winner_o = PTR_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (masked[i]) winner_o = PTR_W'(i);
    for (int i = 0; i < NUM_REQ; i++)
      winner_oh_o[i] = any_req_o && (winner_o == PTR_W'(i));
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Round-robin write arbiter in front of a NUM_REGS-word register bank with one
// combinational read port. Optional locked bursts via `define ARB_LOCK_EN.
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH = 5,
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 3,
  parameter int MAX_BURST   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] wr_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [WORD_LENGTH-1:0]        rd_data
);

  localparam int PTR_W    = clog2(NUM_REQ);
  localparam int NUM_REGS = 2 ** ADDR_W;

  state_e                   state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d, done_q, done_d;
  logic [PTR_W-1:0]         win_q, win_d, rr_ptr_q, rr_ptr_d, ptr_next;
  logic [WORD_LENGTH-1:0]   bank_q [NUM_REGS];

  logic [PTR_W-1:0]         pick_idx;
  logic [NUM_REQ-1:0]       pick_oh;
  logic                     pick_any;

  logic [ADDR_W-1:0]        sel_addr;
  logic [WORD_LENGTH-1:0]   sel_data;
  logic                     wr_active, we;

`ifdef ARB_LOCK_EN
  localparam int               BW         = clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);
  logic [BW-1:0]               burst_q, burst_d;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req_i       (req),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (pick_idx),
    .winner_oh_o (pick_oh),
    .any_req_o   (pick_any)
  );

  // gnt_q is one-hot during GRANT, so it doubles as the write-port mux select.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) begin
        sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
        sel_data = wr_data[i*WORD_LENGTH +: WORD_LENGTH];
      end
  end

  assign wr_active = |(req & gnt_q);
  assign ptr_next  = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    done_d   = '0;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    we       = 1'b0;
`ifdef ARB_LOCK_EN
    burst_d  = burst_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A withdrawn requester simply loses its slot: no write, no done.
        we     = wr_active;
        done_d = req & gnt_q;
`ifdef ARB_LOCK_EN
        if (|(req & lock & gnt_q) && (burst_q < BURST_LAST)) begin
          gnt_d   = gnt_q;
          burst_d = burst_q + 1'b1;
        end else begin
          burst_d  = '0;
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
`else
        rr_ptr_d = ptr_next;
        state_d  = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      win_q    <= '0;
      rr_ptr_q <= '0;
`ifdef ARB_LOCK_EN
      burst_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB_LOCK_EN
      burst_q  <= burst_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (we) begin
      bank_q[sel_addr] <= sel_data;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rd_data = bank_q[rd_addr];

endmodule
